bless_inject_queue: RTL
=======================

Name: bless_inject_queue

Overview:
- Local injection stage directly upstream of the BLESS router's local input port (dinLocal).
- Buffers flits from the core/NI in a small FIFO and presents the head flit to the router.
- Asserts injection only when at least one of the four network input ports is idle this cycle, so the bufferless router always has a free output for the injected flit.
- Tracks injection starvation cycles so a throttling controller can react.

Parameters:
- DW, 64, flit width in bits; equals the router's local input width.
- VALID_BIT, 63, bit position of the flit valid flag inside a flit.
- DEPTH, 4, FIFO entries; must be a power of 2, ≥2.
- CNT_W, 8, starvation counter width.
- STARVE_TH, 32, starvation flag threshold in cycles.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- core_flit  input  DW  flit from core/NI.
- core_valid  input  1  core_flit valid.
- core_ready  output  1  queue can accept a flit.
- net_valid  input  4  valid bits of the W,E,S,N router inputs this cycle.
- dinLocal  output  DW  flit to the router local input; all-zero when not injecting.
- inj_fire  output  1  head flit injected this cycle.
- occupancy  output  log2(DEPTH)+1  stored flit count.
- starve_cnt  output  CNT_W  consecutive blocked cycles.
- starve  output  1  starve_cnt ≥ STARVE_TH.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset values:
  - occupancy=0, rd/wr pointers=0, starve_cnt=0, starve=0.
  - dinLocal=0, inj_fire=0.
  - core_ready=1 in the cycle after reset deasserts.
  - While reset=1, core_ready=0; pushes and pops are ignored.
- Storage is register-based, DEPTH entries, circular pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
- Push:
  - push = core_valid & core_ready.
  - core_ready = (occupancy < DEPTH) | inj_fire.
  - When full, a same-cycle pop frees a slot.
- Injection (combinational from registered state and net_valid):
  - inj_fire = (occupancy ≠ 0) & (popcount(net_valid) ≤ 3).
  - dinLocal = inj_fire ? head entry with bit VALID_BIT forced to 1 : all-zero.
- Pop on the rising edge when inj_fire=1; the head advances.
  - Latency: a flit pushed into an empty queue at edge N is presented on dinLocal in cycle N+1 at the earliest.
  - There is no bypass path.
- Simultaneous push and pop: occupancy unchanged; both pointers advance.
  - With occupancy=1 this stays correct: the new flit becomes the head next cycle.
- Empty: inj_fire=0 and dinLocal=0 regardless of net_valid.
- Starvation counter:
  - If occupancy≠0 and inj_fire=0: starve_cnt increments, saturating at 2^CW-1 (CW = CNT_W).
  - If inj_fire=1 or occupancy=0: starve_cnt clears to 0 at the edge.
  - starve is registered: starve = (starve_cnt_next ≥ STARVE_TH).
- Reset mid-operation discards all queued flits. No flit is presented in the reset cycle or the cycle after.
- Core flit valid bit: core_flit bit VALID_BIT is don't-care on input; only core_valid qualifies a push.
- Flits are delivered to the router in push order (strict FIFO); none are duplicated or dropped.

Test Plan:
- Reset, then push flit 0x...00A5 with net_valid=4'b0000 → cycle after push: inj_fire=1, dinLocal[VALID_BIT]=1, payload 0xA5; occupancy returns to 0.
- Push 4 flits (1,2,3,4) while net_valid=4'b1111 → core_ready=0 when occupancy=4, inj_fire=0, dinLocal=0. Then set net_valid=4'b1110 → flits 1,2,3,4 are emitted in order on 4 consecutive cycles.
- Full queue, net_valid=4'b0111, core_valid=1 with flit 5 → pop and push in the same cycle; occupancy stays 4; flit 5 is emitted after flit 4.
- One queued flit, net_valid=4'b1111 held 40 cycles → starve_cnt reaches 40; starve rises when starve_cnt=32. Release to 4'b0000 → inj_fire=1, then starve_cnt=0 and starve=0 next cycle.
- With CNT_W=4, block for 20 cycles → starve_cnt saturates at 15 and does not wrap.
- Assert reset for one cycle with 3 queued flits → occupancy=0, dinLocal=0, inj_fire=0, no stale flit emitted afterwards.

Source files
------------

// File: rtl/bless_inject_queue.sv
// bless_inject_queue
// Local injection stage sitting in front of the BLESS router's local input.
// Flits from the core/NI are buffered in a small register FIFO. The head flit
// is offered to the router only when at least one of the four network inputs
// is idle. A bufferless router can then always give the injected flit an
// output port. A saturating counter tracks how long a non-empty queue has been
// blocked, and a registered flag raises once that reaches the threshold.

module bless_inject_queue #(
    parameter int DW        = 64,
    parameter int VALID_BIT = 63,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 8,
    parameter int STARVE_TH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DW-1:0]              core_flit,
    input  logic                       core_valid,
    output logic                       core_ready,
    input  logic [3:0]                 net_valid,
    output logic [DW-1:0]              dinLocal,
    output logic                       inj_fire,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           starve_cnt,
    output logic                       starve
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_OCC = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [AW:0]      OCC_ONE  = (AW+1)'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Storage and state registers
    logic [DW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic [CNT_W-1:0] cnt_q;
    logic             starve_q;

    // Combinational helpers
    logic             all_busy;
    logic             push;
    logic             pop;
    logic [AW:0]      occ_next;
    logic [CNT_W-1:0] cnt_next;
    logic [DW-1:0]    head_flit;

    // Injection is allowed only when some network input is idle, so the
    // router keeps a free output. Nothing is injected while reset is held,
    // even if stale occupancy is still sitting in the registers.
    always_comb begin
        all_busy  = &net_valid;
        inj_fire  = !reset && (occ != '0) && !all_busy;
        pop       = inj_fire;
        core_ready = !reset && ((occ < FULL_OCC) || inj_fire);
        push      = core_valid && core_ready;
    end

    // Present the head flit with its valid flag forced on. Otherwise drive
    // all-zero, so the router sees an empty local port.
    always_comb begin
        head_flit = mem[rd_ptr];
        dinLocal  = '0;
        if (inj_fire) begin
            dinLocal            = head_flit;
            dinLocal[VALID_BIT] = 1'b1;
        end
    end

    // Next occupancy: a simultaneous push and pop leaves the count unchanged
    always_comb begin
        occ_next = occ;
        case ({push, pop})
            2'b10:   occ_next = occ + OCC_ONE;
            2'b01:   occ_next = occ - OCC_ONE;
            default: occ_next = occ;
        endcase
    end

    // Starvation counter: counts blocked cycles of a non-empty queue and
    // saturates instead of wrapping; any injection or an empty queue clears it
    always_comb begin
        cnt_next = '0;
        if ((occ != '0) && !inj_fire) begin
            cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    // Flit storage; data registers need no reset because occupancy gates use
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= core_flit;
        end
    end

    // Pointer, occupancy and starvation state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            cnt_q    <= '0;
            starve_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            occ      <= occ_next;
            cnt_q    <= cnt_next;
            starve_q <= (32'(cnt_next) >= 32'(STARVE_TH));
        end
    end

    assign occupancy  = occ;
    assign starve_cnt = cnt_q;
    assign starve     = starve_q;

endmodule
